// File: rtl/spis_mem_sched.sv
// Memory-access scheduler between the SPI slave front end and the single-port RAM (read-first, burst-window translation).
// Optional SPIS_MEM_SCHED_ERR_EN: drop overflowing requests and keep sticky err_ovf / saturating ovf_cnt.
module spis_mem_sched #(
  parameter logic [15:0] WRBUF_BASE = 16'h0200,
  parameter logic [15:0] RDBUF_BASE = 16'h1000,
  parameter int unsigned BUF_DEPTH  = 16
) (
  input  logic        sclk_inv,
  input  logic        rst_n,
  input  logic        ss_n,
  input  logic        spi_write,
  input  logic [15:0] spi_wr_addr,
  input  logic [31:0] spi_wdata,
  input  logic        spi_read,
  input  logic [15:0] spi_rd_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] tx_rdata,
  output logic        rd_valid,
  output logic        busy,
  output logic        err_ovf,
  output logic [7:0]  ovf_cnt
);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDATA} state_t;
  state_t state, state_nxt;

  logic              wr_q, rd_q;
  logic              wr_edge, rd_edge, wr_take, rd_take;
  logic              wr_pend, rd_pend;
  logic [15:0]       wr_addr_l, rd_addr_l;
  logic [31:0]       wdata_l;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              enter_wr, enter_rd;
  logic              wr_is_buf, rd_is_buf;
  logic [15:0]       wr_xlat, rd_xlat;

  assign wr_edge   = spi_write & ~wr_q & ~ss_n;
  assign rd_edge   = spi_read  & ~rd_q & ~ss_n;
  assign enter_wr  = (state_nxt == WRITE);
  assign enter_rd  = (state_nxt == READ);
  assign wr_is_buf = (wr_addr_l == WRBUF_BASE);
  assign rd_is_buf = (rd_addr_l == RDBUF_BASE);
  assign wr_xlat   = wr_is_buf ? WRBUF_BASE + 16'(wr_ptr) : wr_addr_l;
  assign rd_xlat   = rd_is_buf ? RDBUF_BASE + 16'(rd_ptr) : rd_addr_l;

`ifdef SPIS_MEM_SCHED_ERR_EN
  logic wr_ovf, rd_ovf;
  assign wr_ovf  = wr_edge & wr_pend & ~enter_wr;
  assign rd_ovf  = rd_edge & rd_pend & ~enter_rd;
  assign wr_take = wr_edge & ~wr_ovf;
  assign rd_take = rd_edge & ~rd_ovf;

  always_ff @(posedge sclk_inv or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      ovf_cnt <= '0;
    end else if (wr_ovf || rd_ovf) begin
      err_ovf <= 1'b1;
      if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`else
  assign wr_take = wr_edge;
  assign rd_take = rd_edge;
  assign err_ovf = 1'b0;
  assign ovf_cnt = '0;
`endif

  always_ff @(posedge sclk_inv or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ss_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rd_pend) state_nxt = READ; else if (wr_pend) state_nxt = WRITE;
        READ:    state_nxt = RDATA;
        RDATA:   state_nxt = wr_pend ? WRITE : (rd_pend ? READ : IDLE);
        WRITE:   state_nxt = rd_pend ? READ : (wr_pend ? WRITE : IDLE);
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req = (state == READ) || (state == WRITE);
    mem_we  = (state == WRITE);
    busy    = (state != IDLE) || wr_pend || rd_pend;
  end

  // Pends clear on entry to the serving state, so a pend seen while in WRITE/RDATA is always a fresh request.
  always_ff @(posedge sclk_inv or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_addr_l <= '0;
      rd_addr_l <= '0;
      wdata_l   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      wr_q <= spi_write;
      rd_q <= spi_read;
      if (ss_n) begin
        wr_pend <= 1'b0;
        rd_pend <= 1'b0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (enter_wr) begin
          wr_pend <= 1'b0;
          if (wr_is_buf) wr_ptr <= wr_ptr + 1'b1;
        end
        if (enter_rd) begin
          rd_pend <= 1'b0;
          if (rd_is_buf) rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_take) begin
          wr_pend   <= 1'b1;
          wr_addr_l <= spi_wr_addr;
          wdata_l   <= spi_wdata;
        end
        if (rd_take) begin
          rd_pend   <= 1'b1;
          rd_addr_l <= spi_rd_addr;
        end
      end
    end
  end

  always_ff @(posedge sclk_inv or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      tx_rdata  <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (enter_rd) begin
        mem_addr <= rd_xlat;
      end else if (enter_wr) begin
        mem_addr  <= wr_xlat;
        mem_wdata <= wdata_l;
      end
      rd_valid <= (state == RDATA) && !ss_n;
      if ((state == RDATA) && !ss_n) tx_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_spis_mem_sched.sv
// Scoreboard bench for spis_mem_sched: stimulus pushes expected accesses/read data, a negedge monitor pops and compares.
module tb_spis_mem_sched;
  logic        sclk_inv = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        spi_write = 1'b0;
  logic [15:0] spi_wr_addr = '0;
  logic [31:0] spi_wdata = '0;
  logic        spi_read = 1'b0;
  logic [15:0] spi_rd_addr = '0;
  logic        mem_req, mem_we, rd_valid, busy, err_ovf;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, tx_rdata;
  logic [31:0] mem_rdata;
  logic [7:0]  ovf_cnt;

  spis_mem_sched #(.WRBUF_BASE(16'h0200), .RDBUF_BASE(16'h1000), .BUF_DEPTH(16)) dut (
    .sclk_inv(sclk_inv), .rst_n(rst_n), .ss_n(ss_n),
    .spi_write(spi_write), .spi_wr_addr(spi_wr_addr), .spi_wdata(spi_wdata),
    .spi_read(spi_read), .spi_rd_addr(spi_rd_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .tx_rdata(tx_rdata), .rd_valid(rd_valid), .busy(busy),
    .err_ovf(err_ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 sclk_inv = ~sclk_inv;

  int cyc = 0;
  always @(posedge sclk_inv) cyc <= cyc + 1;

  logic [31:0] ram [0:65535];
  always @(posedge sclk_inv) begin
    if (!rst_n) begin
      ram[16'h1000] <= 32'd1;
      ram[16'h1001] <= 32'd2;
      ram[16'h1002] <= 32'd3;
      ram[16'h0100] <= 32'hDEAD_BEEF;
      ram[16'h0101] <= 32'h0000_0101;
      mem_rdata     <= '0;
    end else if (mem_req) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rdx_t;
  acc_t acc_q[$];
  rdx_t rd_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_acc(input logic we, input logic [15:0] addr, input logic [31:0] data, input int c);
    acc_t a;
    a.we = we; a.addr = addr; a.data = data; a.cyc = c;
    acc_q.push_back(a);
  endtask

  task automatic push_rd(input logic [31:0] data, input int c);
    rdx_t r;
    r.data = data; r.cyc = c;
    rd_q.push_back(r);
  endtask

  acc_t ma;
  rdx_t mr;
  always @(negedge sclk_inv) begin
    if (rst_n) begin
      if (mem_req) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL acc_unexpected actual=access addr %h we %b required=no access (cycle %0d)", mem_addr, mem_we, cyc);
        end else begin
          ma = acc_q.pop_front();
          chk("acc_we", {31'b0, mem_we}, {31'b0, ma.we});
          chk("acc_addr", {16'b0, mem_addr}, {16'b0, ma.addr});
          if (ma.we) chk("acc_wdata", mem_wdata, ma.data);
          chk("acc_cycle", cyc, ma.cyc);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=rd_valid data %h required=no rd_valid (cycle %0d)", tx_rdata, cyc);
        end else begin
          mr = rd_q.pop_front();
          chk("rd_data", tx_rdata, mr.data);
          chk("rd_cycle", cyc, mr.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge sclk_inv);
  endtask

  // Request edge sampled at cyc+1; mem_req seen at the negedge after cyc+2, read data after cyc+4.
  task automatic wr_req(input logic [15:0] addr, input logic [31:0] data, input logic [15:0] xaddr);
    tick();
    spi_write = 1'b1; spi_wr_addr = addr; spi_wdata = data;
    push_acc(1'b1, xaddr, data, cyc + 2);
    tick();
    spi_write = 1'b0;
  endtask

  task automatic rd_req(input logic [15:0] addr, input logic [15:0] xaddr, input logic [31:0] data);
    tick();
    spi_read = 1'b1; spi_rd_addr = addr;
    push_acc(1'b0, xaddr, '0, cyc + 2);
    push_rd(data, cyc + 4);
    tick();
    spi_read = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  int r;
  initial begin
    repeat (3) tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_err_ovf", {31'b0, err_ovf}, 32'h0);
    chk("rst_ovf_cnt", {24'b0, ovf_cnt}, 32'h0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_tx_rdata", tx_rdata, 32'h0);
    rst_n = 1'b1;
    ss_n  = 1'b0;
    tick();

    // single pass-through write
    wr_req(16'h0040, 32'hA5A5_0001, 16'h0040);
    wait_idle();

    // three reads through the read burst window
    for (int i = 0; i < 3; i++)
      rd_req(16'h1000, 16'h1000 + 16'(i), 32'(i + 1));
    wait_idle();
    chk("tx_rdata_hold", tx_rdata, 32'd3);

    // 17 buffer writes: pointer wraps after 16
    for (int i = 0; i < 17; i++)
      wr_req(16'h0200, 32'h0000_0100 + 32'(i), 16'h0200 + 16'(i % 16));
    wait_idle();

    // read and write on the same edge: read first, write at E+3, busy falls at E+4
    tick();
    spi_read = 1'b1; spi_rd_addr = 16'h0100;
    spi_write = 1'b1; spi_wr_addr = 16'h0050; spi_wdata = 32'hCAFE_0050;
    r = cyc + 1;
    push_acc(1'b0, 16'h0100, '0, r + 1);
    push_acc(1'b1, 16'h0050, 32'hCAFE_0050, r + 3);
    push_rd(32'hDEAD_BEEF, r + 3);
    tick();
    spi_read = 1'b0; spi_write = 1'b0;
    while (cyc < r + 3) tick();
    chk("busy_e3", {31'b0, busy}, 32'h1);
    tick();
    chk("busy_e4", {31'b0, busy}, 32'h0);

    // ss_n clears the write pointer left at 1 by the wrap test
    tick(); ss_n = 1'b1;
    tick(); tick(); ss_n = 1'b0;
    for (int i = 0; i < 5; i++)
      wr_req(16'h0200, 32'h0000_0500 + 32'(i), 16'h0200 + 16'(i));
    wait_idle();
    tick(); ss_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      spi_write = (i == 1 || i == 2); spi_wr_addr = 16'h0200; spi_wdata = 32'hBAD0_0000;
      spi_read  = (i == 3); spi_rd_addr = 16'h1000;
      chk("ssn_no_req", {31'b0, mem_req}, 32'h0);
    end
    spi_write = 1'b0; spi_read = 1'b0;
    tick(); ss_n = 1'b0;
    tick();
    chk("ssn_ignored", {31'b0, busy}, 32'h0);
    wr_req(16'h0200, 32'h0000_0600, 16'h0200);
    wait_idle();
    chk("no_ovf_yet", {31'b0, err_ovf}, 32'h0);

    // second write edge while the FSM is held by a read
    tick();
    spi_read = 1'b1; spi_rd_addr = 16'h0101;
    spi_write = 1'b1; spi_wr_addr = 16'h0060; spi_wdata = 32'h1111_1111;
    r = cyc + 1;
    push_acc(1'b0, 16'h0101, '0, r + 1);
    push_rd(32'h0000_0101, r + 3);
    tick();
    spi_read = 1'b0; spi_write = 1'b0;
    tick();
    spi_write = 1'b1; spi_wr_addr = 16'h0061; spi_wdata = 32'h2222_2222;
`ifdef SPIS_MEM_SCHED_ERR_EN
    push_acc(1'b1, 16'h0060, 32'h1111_1111, r + 3);
`else
    push_acc(1'b1, 16'h0061, 32'h2222_2222, r + 3);
`endif
    tick();
    spi_write = 1'b0;
    wait_idle();
`ifdef SPIS_MEM_SCHED_ERR_EN
    chk("ovf_flag", {31'b0, err_ovf}, 32'h1);
    chk("ovf_cnt", {24'b0, ovf_cnt}, 32'h1);
`else
    chk("ovf_flag", {31'b0, err_ovf}, 32'h0);
    chk("ovf_cnt", {24'b0, ovf_cnt}, 32'h0);
`endif

    repeat (4) tick();
    chk("acc_q_drained", acc_q.size(), 32'h0);
    chk("rd_q_drained", rd_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
